// File: rtl/oled_phy.sv
// oled_phy: physical-layer driver for the PmodOLEDrgb (SSD1331) panel.
//   - Sequences the panel rails on power-up: VDD, then a reset pulse, then VCC.
//     On power-down it drops VCC, lets any frame in progress finish, then drops VDD.
//   - Sends command/data bytes on SPI mode 3. Each byte goes in its own CS frame,
//     MSB first.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   power_on              level request: 1 = panel powered, 0 = shut down
//   tx_valid/tx_ready     byte handshake; tx_data/tx_dc are latched on accept
//   tx_data, tx_dc        byte to send and its D/C flag (0 = command, 1 = data)
//   pwr_ready             panel powered and link usable
//   cs, sclk, mosi, dc_c  SPI pins (cs active low, sclk idles high)
//   res, vss_en, pmod_en  panel reset (active low), VCC enable, VDD enable
module oled_phy #(
    parameter int CLK_DIV = 8,
    parameter int T_VDD   = 2000000,
    parameter int T_RES   = 300,
    parameter int T_VCC   = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    output logic       pwr_ready,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    output logic       dc_c,
    output logic       res,
    output logic       vss_en,
    output logic       pmod_en
);
    localparam int MAX_A = (CLK_DIV > T_VDD) ? CLK_DIV : T_VDD;
    localparam int MAX_B = (T_RES > T_VCC) ? T_RES : T_VCC;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] VDD_END = CW'(T_VDD - 1);
    localparam logic [CW-1:0] RES_END = CW'(T_RES - 1);
    localparam logic [CW-1:0] VCC_END = CW'(T_VCC - 1);

    typedef enum logic [2:0] {
        P_OFF, P_VDD_WAIT, P_RES_LOW, P_RES_SETTLE, P_VCC_WAIT, P_READY, P_SHUTDOWN
    } pstate_e;

    typedef enum logic [2:0] {
        F_IDLE, F_SETUP, F_LOW, F_HIGH, F_HOLD, F_GAP
    } fstate_e;

    pstate_e       pstate_q;
    fstate_e       fstate_q;
    logic [CW-1:0] pcnt_q;
    logic [CW-1:0] fcnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_ready_q, pwr_ready_q, cs_q, sclk_q, mosi_q, dc_q;
    logic          res_q, vss_en_q, pmod_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q    <= P_OFF;
            fstate_q    <= F_IDLE;
            pcnt_q      <= '0;
            fcnt_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            tx_ready_q  <= 1'b0;
            pwr_ready_q <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            dc_q        <= 1'b0;
            res_q       <= 1'b1;
            vss_en_q    <= 1'b0;
            pmod_en_q   <= 1'b0;
        end else begin
            // ---------------- byte frame ----------------
            case (fstate_q)
                F_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        tx_ready_q <= 1'b0;
                        cs_q       <= 1'b0;
                        dc_q       <= tx_dc;
                        mosi_q     <= tx_data[7];
                        shreg_q    <= tx_data;
                        bit_q      <= '0;
                        fcnt_q     <= '0;
                        fstate_q   <= F_SETUP;
                    end
                end
                F_SETUP: begin
                    if (fcnt_q == DIV_END) begin
                        // First fall: bit 7 is already on mosi.
                        sclk_q   <= 1'b0;
                        fcnt_q   <= '0;
                        fstate_q <= F_LOW;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                F_LOW: begin
                    if (fcnt_q == DIV_END) begin
                        sclk_q   <= 1'b1;
                        fcnt_q   <= '0;
                        fstate_q <= F_HIGH;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                F_HIGH: begin
                    if (fcnt_q == DIV_END) begin
                        fcnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            fstate_q <= F_HOLD;
                        end else begin
                            // Falls 2..8 present the next bit.
                            sclk_q   <= 1'b0;
                            mosi_q   <= shreg_q[6];
                            shreg_q  <= {shreg_q[6:0], 1'b0};
                            bit_q    <= bit_q + 1'b1;
                            fstate_q <= F_LOW;
                        end
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                F_HOLD: begin
                    if (fcnt_q == DIV_END) begin
                        cs_q     <= 1'b1;
                        fcnt_q   <= '0;
                        fstate_q <= F_GAP;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                F_GAP: begin
                    if (fcnt_q == DIV_END) begin
                        fcnt_q     <= '0;
                        tx_ready_q <= (pstate_q == P_READY) && power_on;
                        fstate_q   <= F_IDLE;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                default: fstate_q <= F_IDLE;
            endcase

            // ---------------- power sequencing ----------------
            case (pstate_q)
                P_OFF: begin
                    if (power_on) begin
                        pmod_en_q <= 1'b1;
                        pcnt_q    <= '0;
                        pstate_q  <= P_VDD_WAIT;
                    end
                end
                P_VDD_WAIT: begin
                    if (pcnt_q == VDD_END) begin
                        res_q    <= 1'b0;
                        pcnt_q   <= '0;
                        pstate_q <= P_RES_LOW;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                P_RES_LOW: begin
                    if (pcnt_q == RES_END) begin
                        res_q    <= 1'b1;
                        pcnt_q   <= '0;
                        pstate_q <= P_RES_SETTLE;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                P_RES_SETTLE: begin
                    if (pcnt_q == RES_END) begin
                        vss_en_q <= 1'b1;
                        pcnt_q   <= '0;
                        pstate_q <= P_VCC_WAIT;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                P_VCC_WAIT: begin
                    if (pcnt_q == VCC_END) begin
                        pwr_ready_q <= 1'b1;
                        tx_ready_q  <= 1'b1;
                        pcnt_q      <= '0;
                        pstate_q    <= P_READY;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                P_READY: ;
                P_SHUTDOWN: begin
                    // Wait for the frame engine (including its CS-high gap) to go idle.
                    if (fstate_q == F_IDLE) begin
                        pmod_en_q <= 1'b0;
                        res_q     <= 1'b1;
                        pstate_q  <= P_OFF;
                    end
                end
                default: pstate_q <= P_OFF;
            endcase

            // Shutdown request overrides any pending step of the power sequence
            // and any tx_ready re-assertion scheduled above.
            if (!power_on && pstate_q != P_OFF && pstate_q != P_SHUTDOWN) begin
                vss_en_q    <= 1'b0;
                pwr_ready_q <= 1'b0;
                tx_ready_q  <= 1'b0;
                pcnt_q      <= '0;
                pstate_q    <= P_SHUTDOWN;
            end
        end
    end

    assign tx_ready  = tx_ready_q;
    assign pwr_ready = pwr_ready_q;
    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign dc_c      = dc_q;
    assign res       = res_q;
    assign vss_en    = vss_en_q;
    assign pmod_en   = pmod_en_q;

endmodule

// File: tb/tb_oled_phy.sv
// tb_oled_phy: directed bench for oled_phy with short timing parameters.
module tb_oled_phy;
    localparam int CLK_DIV = 2;
    localparam int T_VDD   = 10;
    localparam int T_RES   = 4;
    localparam int T_VCC   = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       power_on = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_dc = 1'b0;
    logic       tx_ready, pwr_ready, cs, sclk, mosi, dc_c, res, vss_en, pmod_en;

    oled_phy #(
        .CLK_DIV(CLK_DIV),
        .T_VDD  (T_VDD),
        .T_RES  (T_RES),
        .T_VCC  (T_VCC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .power_on (power_on),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_dc    (tx_dc),
        .pwr_ready(pwr_ready),
        .cs       (cs),
        .sclk     (sclk),
        .mosi     (mosi),
        .dc_c     (dc_c),
        .res      (res),
        .vss_en   (vss_en),
        .pmod_en  (pmod_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI frame monitor: records each CS-low frame as seen on the pins.
    int         cyc = 0, nfr = 0, hi_run = 0;
    int         cur_len = 0, cur_rises = 0, cur_start = 0, cur_gap = 0;
    logic [7:0] cur_cap = 8'h00;
    logic       cur_dc = 1'b0, cur_dcbad = 1'b0;
    logic       prev_cs = 1'b1, prev_sclk = 1'b1;
    logic [7:0] fr_byte [16];
    int         fr_rises[16], fr_len[16], fr_start[16], fr_gap[16];
    logic       fr_dc[16], fr_dcbad[16];

    always @(negedge clk) begin
        cyc++;
        if (cs === 1'b0) begin
            if (prev_cs) begin
                cur_len = 0; cur_rises = 0; cur_cap = 8'h00;
                cur_dc = dc_c; cur_dcbad = 1'b0;
                cur_start = cyc; cur_gap = hi_run;
            end
            cur_len++;
            if (sclk && !prev_sclk) begin
                cur_cap = {cur_cap[6:0], mosi};
                cur_rises++;
            end
            if (dc_c !== cur_dc) cur_dcbad = 1'b1;
            hi_run = 0;
        end else begin
            if (!prev_cs && nfr < 16) begin
                fr_byte[nfr] = cur_cap;   fr_rises[nfr] = cur_rises;
                fr_len[nfr]  = cur_len;   fr_start[nfr] = cur_start;
                fr_gap[nfr]  = cur_gap;   fr_dc[nfr]    = cur_dc;
                fr_dcbad[nfr] = cur_dcbad;
                nfr++;
            end
            hi_run++;
        end
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    // Raise power_on from OFF and time each rail event (cycle 1 = first cycle after the sampling edge).
    task automatic powerup(input string tag);
        int t_pm = -1, t_rl = -1, t_rh = -1, t_vs = -1, t_pr = -1, t_tr = -1;
        power_on = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (pmod_en && t_pm < 0) t_pm = c;
            if (!res && t_rl < 0) t_rl = c;
            if (res && t_rl >= 0 && t_rh < 0) t_rh = c;
            if (vss_en && t_vs < 0) t_vs = c;
            if (pwr_ready && t_pr < 0) t_pr = c;
            if (tx_ready && t_tr < 0) t_tr = c;
        end
        chk({tag, ".pmod_en_rise"}, t_pm, 1);
        chk({tag, ".res_fall"}, t_rl, 11);
        chk({tag, ".res_rise"}, t_rh, 15);
        chk({tag, ".vss_en_rise"}, t_vs, 19);
        chk({tag, ".pwr_ready_rise"}, t_pr, 31);
        chk({tag, ".tx_ready_rise"}, t_tr, 31);
    endtask

    // Present a byte while tx_ready=1; returns at cycle A+1 with tx_valid dropped.
    task automatic accept(input logic [7:0] d, input logic dc);
        tx_data  = d;
        tx_dc    = dc;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Called at A+1: returns the number of cycles from accept to tx_ready high.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (tx_ready !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, f0, cnt;
        logic seen;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {cs, sclk, mosi, dc_c, res, vss_en, pmod_en, tx_ready, pwr_ready},
            9'b110010000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("off.idle", {pmod_en, vss_en, res, tx_ready}, 4'b0010);

        powerup("pu1");

        // Single byte 0xA5, command
        chk("a5.ready_pre", tx_ready, 1);
        f0 = nfr;
        accept(8'hA5, 1'b0);
        chk("a5.first_cycle", {cs, mosi, dc_c, tx_ready}, 4'b0100);
        wait_ready(lat);
        chk("a5.ready_latency", lat, 39);
        chk("a5.nframes", nfr - f0, 1);
        chk("a5.byte", fr_byte[f0], 8'hA5);
        chk("a5.rises", fr_rises[f0], 8);
        chk("a5.cs_low_len", fr_len[f0], 36);
        chk("a5.dc", {fr_dc[f0], fr_dcbad[f0]}, 2'b00);

        // Back-to-back with tx_valid held
        f0 = nfr;
        tx_data = 8'h81; tx_dc = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF; tx_dc = 1'b1;
        cnt = 0;
        while (tx_ready !== 1'b1 && cnt < 80) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b.held_wait", cnt, 38);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_ready(lat);
        chk("b2b.ready_latency", lat, 39);
        chk("b2b.nframes", nfr - f0, 2);
        chk("b2b.byte0", {fr_byte[f0], fr_dc[f0], fr_dcbad[f0]}, {8'h81, 2'b00});
        chk("b2b.byte1", {fr_byte[f0+1], fr_dc[f0+1], fr_dcbad[f0+1]}, {8'hFF, 2'b10});
        chk("b2b.rises1", fr_rises[f0+1], 8);
        chk("b2b.start_spacing", fr_start[f0+1] - fr_start[f0], 39);
        chk("b2b.gap_ge2", (fr_gap[f0+1] >= 2), 1);

        // Shutdown at the 3rd rising edge of 0x3C
        f0 = nfr;
        accept(8'h3C, 1'b0);
        repeat (12) @(negedge clk);
        chk("sd.at_rise3", {cs, sclk}, 2'b01);
        power_on = 1'b0;
        @(negedge clk);
        chk("sd.rails_drop", {vss_en, pwr_ready, cs}, 3'b000);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_ready) cnt++;
        end
        chk("sd.tx_ready_low", cnt, 0);
        chk("sd.byte", fr_byte[f0], 8'h3C);
        chk("sd.rises", fr_rises[f0], 8);
        chk("sd.cs_low_len", fr_len[f0], 36);
        chk("sd.off", {pmod_en, res, vss_en, cs}, 4'b0101);

        powerup("pu2");

        // Abort during RES_LOW
        power_on = 1'b0;
        repeat (20) @(negedge clk);
        power_on = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort.res_low", {res, pmod_en, vss_en}, 3'b010);
        power_on = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vss_en) seen = 1'b1;
        end
        chk("abort.vss_never", seen, 0);
        chk("abort.off", {res, pmod_en}, 2'b10);

        powerup("pu3");

        // rst_n mid-frame after the 4th rising edge
        accept(8'h5A, 1'b1);
        repeat (16) @(negedge clk);
        chk("rst.at_rise4", {cs, sclk}, 2'b01);
        #1 rst_n = 1'b0;
        #1 chk("rst.async", {cs, sclk, pmod_en, vss_en, pwr_ready, tx_ready}, 6'b110000);
        power_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sclk || !cs) cnt++;
        end
        chk("rst.quiet", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
